// File: rtl/drum_pkg.sv
// Shared types for the drum step scheduler: FSM states, 1.17 sample type,
// memory address width and the pluck-shape initial value helper.
package drum_pkg;

  localparam int unsigned ADDR_W = 5;

  typedef logic signed [17:0] sample_t;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StPrimeRd,
    StPrimeLd,
    StRd,
    StLd,
    StWr
  } state_e;

  // Triangular pluck: STEP * min(row, 2*center - row), clamped at zero.
  function automatic sample_t pluck_val(input int row, input int center, input sample_t step);
    int m;
    m = 2 * center - row;
    if (row < m) m = row;
    if (m < 0) m = 0;
    return sample_t'(m * int'(step));
  endfunction

endpackage

// File: rtl/drum_step_sched.sv
// Sequences one drum-column time step over external M10Ks and an external node datapath.
// Optional DRUM_PLUCK_INIT_EN adds an INIT phase that writes a pluck shape into both memories.
module drum_step_sched
  import drum_pkg::*;
#(
  parameter int unsigned ROWS   = 30,
  parameter int unsigned CENTER = 15,
  parameter sample_t     STEP   = 18'h01FFE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              init_done,
  output logic [ADDR_W-1:0] curr_raddr,
  output logic [ADDR_W-1:0] curr_waddr,
  output logic              curr_we,
  output sample_t           curr_d,
  input  sample_t           curr_q,
  output logic [ADDR_W-1:0] prev_raddr,
  output logic [ADDR_W-1:0] prev_waddr,
  output logic              prev_we,
  output sample_t           prev_d,
  input  sample_t           prev_q,
  output sample_t           node_curr,
  output sample_t           node_prev,
  output sample_t           node_up,
  output sample_t           node_down,
  input  sample_t           node_next,
  output sample_t           amp_out,
  output logic              amp_valid
);

  localparam logic [ADDR_W-1:0] LastRow   = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CenterRow = ADDR_W'(CENTER);
`ifdef DRUM_PLUCK_INIT_EN
  localparam state_e ResetSt = StInit;
`else
  localparam state_e ResetSt = StIdle;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  sample_t           curr_reg_q, curr_reg_d;
  sample_t           prev_reg_q, prev_reg_d;
  sample_t           up_reg_q, up_reg_d;
  sample_t           down_reg_q, down_reg_d;
  sample_t           amp_q, amp_d;
  logic              done_q, done_d;
  logic              amp_valid_q, amp_valid_d;
  logic              init_done_q, init_done_d;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    curr_reg_d  = curr_reg_q;
    prev_reg_d  = prev_reg_q;
    up_reg_d    = up_reg_q;
    down_reg_d  = down_reg_q;
    amp_d       = amp_q;
    done_d      = 1'b0;
    amp_valid_d = 1'b0;
    init_done_d = init_done_q;
    curr_raddr  = '0;
    curr_waddr  = '0;
    curr_we     = 1'b0;
    curr_d      = '0;
    prev_raddr  = '0;
    prev_waddr  = '0;
    prev_we     = 1'b0;
    prev_d      = '0;
`ifndef DRUM_PLUCK_INIT_EN
    init_done_d = 1'b1;
`endif

    unique case (state_q)
      StIdle: begin
        if (start && init_done_q) state_d = StPrimeRd;
      end
      StInit: begin
`ifdef DRUM_PLUCK_INIT_EN
        curr_we    = 1'b1;
        prev_we    = 1'b1;
        curr_waddr = row_q;
        prev_waddr = row_q;
        curr_d     = pluck_val(int'(row_q), int'(CENTER), STEP);
        prev_d     = curr_d;
        if (row_q == LastRow) begin
          row_d       = '0;
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          row_d = row_q + 5'd1;
        end
`else
        state_d = StIdle;
`endif
      end
      StPrimeRd: begin
        curr_raddr = '0;
        state_d    = StPrimeLd;
      end
      StPrimeLd: begin
        curr_reg_d = curr_q;
        down_reg_d = '0;
        row_d      = '0;
        state_d    = StRd;
      end
      StRd: begin
        // Last row has no upper neighbour; keep the address in range.
        curr_raddr = (row_q < LastRow) ? row_q + 5'd1 : row_q;
        prev_raddr = row_q;
        state_d    = StLd;
      end
      StLd: begin
        up_reg_d   = (row_q == LastRow) ? '0 : curr_q;
        prev_reg_d = prev_q;
        state_d    = StWr;
      end
      StWr: begin
        curr_we    = 1'b1;
        curr_waddr = row_q;
        curr_d     = node_next;
        prev_we    = 1'b1;
        prev_waddr = row_q;
        prev_d     = curr_reg_q;
        // Slide the three-row window up by one.
        down_reg_d = curr_reg_q;
        curr_reg_d = up_reg_q;
        if (row_q == CenterRow) amp_d = node_next;
        if (row_q == LastRow) begin
          done_d      = 1'b1;
          amp_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          row_d   = row_q + 5'd1;
          state_d = StRd;
        end
      end
      default: state_d = StIdle;
    endcase

    // A reset cycle must never commit a write.
    if (reset) begin
      curr_we = 1'b0;
      prev_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ResetSt;
      row_q       <= '0;
      curr_reg_q  <= '0;
      prev_reg_q  <= '0;
      up_reg_q    <= '0;
      down_reg_q  <= '0;
      amp_q       <= '0;
      done_q      <= 1'b0;
      amp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      curr_reg_q  <= curr_reg_d;
      prev_reg_q  <= prev_reg_d;
      up_reg_q    <= up_reg_d;
      down_reg_q  <= down_reg_d;
      amp_q       <= amp_d;
      done_q      <= done_d;
      amp_valid_q <= amp_valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign amp_valid = amp_valid_q;
  assign amp_out   = amp_q;
  assign init_done = init_done_q;
  assign node_curr = curr_reg_q;
  assign node_prev = prev_reg_q;
  assign node_up   = up_reg_q;
  assign node_down = down_reg_q;

endmodule

// File: tb/tb_drum_step_sched.sv
// Randomized bench for drum_step_sched with behavioural M10Ks, a stand-in drum node
// and a whole-column reference model of one time step.
module tb_drum_step_sched;
  import drum_pkg::*;

  localparam int R = 30;
  localparam int C = 15;
  localparam int Latency = 2 + 3 * R;
`ifdef DRUM_PLUCK_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, init_done, amp_valid;
  logic [4:0]  curr_raddr, curr_waddr, prev_raddr, prev_waddr;
  logic        curr_we, prev_we;
  sample_t     curr_d, curr_q, prev_d, prev_q;
  sample_t     node_curr, node_prev, node_up, node_down, node_next, amp_out;

  always #5 clk = ~clk;

  drum_step_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .init_done (init_done),
    .curr_raddr(curr_raddr),
    .curr_waddr(curr_waddr),
    .curr_we   (curr_we),
    .curr_d    (curr_d),
    .curr_q    (curr_q),
    .prev_raddr(prev_raddr),
    .prev_waddr(prev_waddr),
    .prev_we   (prev_we),
    .prev_d    (prev_d),
    .prev_q    (prev_q),
    .node_curr (node_curr),
    .node_prev (node_prev),
    .node_up   (node_up),
    .node_down (node_down),
    .node_next (node_next),
    .amp_out   (amp_out),
    .amp_valid (amp_valid)
  );

  // Stand-in drum node: any fixed function of the four neighbours will do.
  function automatic sample_t drum_f(sample_t c, sample_t p, sample_t u, sample_t d);
    int s;
    s = ((int'(u) + int'(d)) >>> 1) - int'(p) + (int'(c) >>> 2);
    return sample_t'(s);
  endfunction

  assign node_next = drum_f(node_curr, node_prev, node_up, node_down);

  sample_t    curr_mem[32];
  sample_t    prev_mem[32];
  logic       ld_en = 1'b0;
  logic [4:0] ld_addr;
  sample_t    ld_c, ld_p;

  always @(posedge clk) begin
    curr_q <= curr_mem[curr_raddr];
    prev_q <= prev_mem[prev_raddr];
    if (curr_we) curr_mem[curr_waddr] <= curr_d;
    if (prev_we) prev_mem[prev_waddr] <= prev_d;
    if (ld_en) begin
      curr_mem[ld_addr] <= ld_c;
      prev_mem[ld_addr] <= ld_p;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int      addr_viol = 0, av_mismatch = 0, we_early = 0, up_viol = 0, down_viol = 0;
  int      wr_top = 0, wr_bot = 0;
  bit      started = 1'b0, stepping = 1'b0;
  sample_t amp_wr_val;

  always @(negedge clk) begin
    if (!reset) begin
      if (curr_raddr > R - 1 || curr_waddr > R - 1 || prev_raddr > R - 1 || prev_waddr > R - 1)
        addr_viol++;
      if (amp_valid !== done) av_mismatch++;
      if (!InitEn && !started && (curr_we || prev_we)) we_early++;
      if (stepping && curr_we) begin
        if (curr_waddr == 5'(R - 1)) begin
          wr_top++;
          if (node_up !== '0) up_viol++;
        end
        if (curr_waddr == 5'd0) begin
          wr_bot++;
          if (node_down !== '0) down_viol++;
        end
        if (curr_waddr == 5'(C)) amp_wr_val = node_next;
      end
    end
  end

  sample_t c0[R], p0[R], exp_c[R], exp_p[R];
  sample_t exp_amp;

  task automatic preload();
    for (int i = 0; i < R; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 5'(i);
      ld_c    = sample_t'($urandom);
      ld_p    = sample_t'($urandom);
      c0[i]   = ld_c;
      p0[i]   = ld_p;
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One explicit-scheme step computed over the whole column at once.
  task automatic model_step();
    for (int i = 0; i < R; i++) begin
      sample_t up, dn;
      up       = (i == R - 1) ? sample_t'(0) : c0[i + 1];
      dn       = (i == 0) ? sample_t'(0) : c0[i - 1];
      exp_c[i] = drum_f(c0[i], p0[i], up, dn);
      exp_p[i] = c0[i];
    end
    exp_amp = exp_c[C];
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("init_latency", 64'(n), 64'(R));
    check("init_row0_curr", curr_mem[0], 18'h00000);
    check("init_row15_curr", curr_mem[15], 18'h1DFE2);
    check("init_row29_curr", curr_mem[29], 18'h01FFE);
    check("init_row0_prev", prev_mem[0], 18'h00000);
    check("init_row15_prev", prev_mem[15], 18'h1DFE2);
    check("init_row29_prev", prev_mem[29], 18'h01FFE);
  endtask

  task automatic do_step(input bit extra, input int rst_at);
    int n, first_done, ndone;
    preload();
    model_step();
    started  = 1'b1;
    stepping = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    first_done = -1;
    ndone = 0;
    while (n < 130) begin
      @(negedge clk);
      if (n == 1) check("busy_in_step", busy, 1'b1);
      if (rst_at >= 0 && n == rst_at) begin
        start = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_we_same_cycle", {curr_we, prev_we}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check("rst_we_next", {curr_we, prev_we}, 2'b00);
        check("rst_busy", busy, InitEn);
        check("rst_done", {done, amp_valid}, 2'b00);
        check("rst_amp", amp_out, 18'h0);
        check("rst_node_curr", node_curr, 18'h0);
        reset    = 1'b0;
        stepping = 1'b0;
        if (InitEn) begin
          wait_init();
        end else begin
          @(posedge clk);
          @(negedge clk);
          check("rst_init_done", init_done, 1'b1);
        end
        return;
      end
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      start = extra && (n == 0 || n == 39);
      @(posedge clk);
      n++;
    end
    stepping = 1'b0;
    check("done_latency", 64'(first_done), 64'(Latency));
    check("done_count", 64'(ndone), 64'd1);
    check("amp_model", amp_out, exp_amp);
    check("amp_node_next", amp_out, amp_wr_val);
    for (int i = 0; i < R; i++) begin
      check($sformatf("curr_row%0d", i), curr_mem[i], exp_c[i]);
      check($sformatf("prev_row%0d", i), prev_mem[i], exp_p[i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, InitEn);
    check("reset_done", {done, amp_valid}, 2'b00);
    check("reset_amp", amp_out, 18'h0);
    check("reset_nodes", {node_curr, node_prev, node_up, node_down}, 72'h0);
    reset = 1'b0;
    if (InitEn) begin
      wait_init();
    end else begin
      @(posedge clk);
      @(negedge clk);
      check("init_done_1cyc", init_done, 1'b1);
      check("init_done_idle", busy, 1'b0);
    end
    repeat (5) @(negedge clk);
    do_step(1'b0, -1);
    do_step(1'b0, -1);
    do_step(1'b1, -1);
    do_step(1'b0, 40);
    do_step(1'b0, -1);
    check("addr_range", 64'(addr_viol), 64'd0);
    check("amp_valid_with_done", 64'(av_mismatch), 64'd0);
    check("no_early_we", 64'(we_early), 64'd0);
    check("top_up_zero", 64'(up_viol), 64'd0);
    check("bot_down_zero", 64'(down_viol), 64'd0);
    check("top_wr_seen", 64'(wr_top > 0), 64'd1);
    check("bot_wr_seen", 64'(wr_bot > 0), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drum_step_sched.md
DRUM_STEP_SCHED -- requirements
Module: drum_step_sched

Interface
REQ-001 SHALL have parameter ROWS, default 30, meaning node count of one column (max 32).
REQ-002 SHALL have parameter CENTER, default 15, meaning the row whose value is reported as amplitude.
REQ-003 SHALL have parameter STEP, default 18'h01FFE (1.17), meaning the init ramp increment per row.
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-005 SHALL have port start  in  1  one-step request (audio sample tick).
REQ-006 SHALL have port busy  out  1  step or init in progress; done  out  1  one-cycle step-complete pulse; init_done  out  1  memories initialised.
REQ-007 SHALL have ports curr_raddr/curr_waddr  out  5, curr_we  out  1, curr_d  out  18, curr_q  in  18: current-state M10K (1-cycle read latency).
REQ-008 SHALL have ports prev_raddr/prev_waddr  out  5, prev_we  out  1, prev_d  out  18, prev_q  in  18: previous-state M10K.
REQ-009 SHALL have ports node_curr, node_prev, node_up, node_down  out  18 signed, and node_next  in  18 signed: drum node datapath, combinational.
REQ-010 SHALL have ports amp_out  out  18 signed and amp_valid  out  1: row-CENTER amplitude.

Function
REQ-011 SHALL use the states IDLE, INIT, PRIME_RD, PRIME_LD, RD, LD, WR.
REQ-012 IDLE: when start=1 and init_done=1, go to PRIME_RD; otherwise stay in IDLE.
REQ-013 PRIME_RD SHALL drive curr_raddr=0. PRIME_LD SHALL latch curr_reg<=curr_q and down_reg<=0, then set row=0.
REQ-014 RD SHALL drive curr_raddr=row+1 (if row<ROWS-1) and prev_raddr=row.
REQ-015 LD SHALL latch up_reg<=curr_q, or 0 when row==ROWS-1, and prev_reg<=prev_q.
REQ-016 node_curr=curr_reg, node_prev=prev_reg, node_up=up_reg, node_down=down_reg SHALL hold stable through WR; node_down SHALL be 0 at row 0.
REQ-017 WR SHALL, in a single cycle, do: curr_we=1, curr_waddr=row, curr_d=node_next; prev_we=1, prev_waddr=row, prev_d=curr_reg; down_reg<=curr_reg; curr_reg<=up_reg.
REQ-018 After WR, if row<ROWS-1 SHALL do row+1 and go to RD; otherwise go to IDLE with done=1 for one cycle.
REQ-019 Step latency SHALL be done asserted exactly 2+3*ROWS cycles after the edge that accepts start (92 at ROWS=30).
REQ-020 At WR of row CENTER SHALL latch amp_out<=node_next; amp_valid SHALL pulse together with done; amp_out SHALL hold between steps.
REQ-021 start while busy=1 SHALL be ignored and not queued; start during INIT SHALL be ignored.
REQ-022 Write enables SHALL be asserted only in WR and INIT; addresses SHALL never exceed ROWS-1.
REQ-023 The row counter SHALL be 5 bits; it SHALL never wrap past ROWS-1.

Reset
REQ-024 Reset SHALL force state to INIT (macro on) or IDLE (macro off), row=0, busy=0 (IDLE) / 1 (INIT), done=0, amp_valid=0, amp_out=0, all we=0, and all node_* and internal registers to 0.
REQ-025 Reset mid-step SHALL abort with no write in the following cycle; partially updated rows are not restored.

Configuration
REQ-026 With DRUM_PLUCK_INIT_EN defined: INIT SHALL write row i of both memories with STEP*min(i, 2*CENTER-i), one row per cycle for ROWS cycles; init_done SHALL then rise and the state SHALL go to IDLE.
REQ-027 With DRUM_PLUCK_INIT_EN undefined: INIT SHALL not exist; init_done=1 from the first cycle after reset; memories are not written by this block.

Structure
REQ-028 A shared package drum_pkg SHALL hold the state enum, the 18-bit 1.17 sample typedef, and ADDR_W=5.
REQ-029 The block SHALL contain no sub-modules; the M10K and drum node SHALL stay external, wired at the top level.

Verification
REQ-030 Macro on, reset released: rows 0/15/29 of both memories SHALL be 0/0x1DFE2/0x01FFE, with init_done high 30 cycles later.
REQ-031 A single start with behavioural M10Ks and drum node: done SHALL occur 92 cycles later, and the memory contents SHALL match a golden model of one step.
REQ-032 Row 29 WR: node_up SHALL be 0; row 0 WR: node_down SHALL be 0; amp_out SHALL equal node_next at row 15.
REQ-033 start pulsed at accept+1 and accept+40: exactly one done SHALL occur, at accept+92.
REQ-034 Reset at cycle 40 of a step: curr_we/prev_we SHALL be 0 next cycle, and busy=0 or INIT re-entered according to the macro.
REQ-035 Macro off: init_done SHALL be 1 one cycle after reset, with no write enables asserted before the first start.
